// File: rtl/dmem_responder.sv
// Data-port memory target: valid/ready request in, word RAM, response after
// WAIT_CYCLES wait states. Misaligned or out-of-range accesses return rsp_err.
module dmem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [3:0]            req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    rerr_q, rerr_d;

    logic                    we_q;
    logic [3:0]              be_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic                    err_q;

    logic [DATA_WIDTH-1:0]   mem_q [2**ADDR_WIDTH];

    logic                    idle;
    logic                    accept;
    logic                    commit;
    logic                    c_we;
    logic [3:0]              c_be;
    logic [DATA_WIDTH-1:0]   c_wdata;
    logic [ADDR_WIDTH-1:0]   c_idx;
    logic                    c_err;

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (|a[31:ADDR_WIDTH+2]);
    endfunction

    assign idle   = (state_q == IDLE);
    assign accept = idle && req_valid;

    // Zero-wait transactions commit on the accept edge, straight from the inputs.
    assign c_we    = idle ? req_we                        : we_q;
    assign c_be    = idle ? req_be                        : be_q;
    assign c_wdata = idle ? req_wdata                     : wdata_q;
    assign c_idx   = idle ? req_addr[ADDR_WIDTH+1:2]      : idx_q;
    assign c_err   = idle ? addr_err(req_addr)            : err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    rerr_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            rerr_d  = c_err;
            rdata_d = (c_we || c_err) ? '0 : mem_q[c_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
        end
    end

    // Request capture and storage carry no reset; they are only read after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            be_q    <= req_be;
            wdata_q <= req_wdata;
            idx_q   <= req_addr[ADDR_WIDTH+1:2];
            err_q   <= addr_err(req_addr);
        end
        if (commit && c_we && !c_err) begin
            for (int i = 0; i < 4; i++) begin
                if (c_be[i]) mem_q[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
            end
        end
    end

    assign req_ready = idle && !rst;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rerr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder with two wait states, one with none.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_ready = 1'b0;

    logic        rv2 = 1'b0, rv0 = 1'b0;
    logic        rdy2, rdy0, vld2, vld0, err2, err0;
    logic [31:0] rd2, rd0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(rv2), .req_ready(rdy2), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(vld2), .rsp_ready(rsp_ready), .rsp_rdata(rd2), .rsp_err(err2)
    );

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rdy0), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(vld0), .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_err(err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction on the two-wait-state responder, entered and left at a negedge.
    task automatic txn2(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input bit keep_valid, input int hold,
                        output int lat, output logic [31:0] rd, output logic er);
        req_we = we; req_addr = a; req_wdata = wd; req_be = be;
        rv2 = 1'b1; rsp_ready = 1'b0;
        chk("ready_before_accept", 32'(rdy2), 32'd1);
        @(negedge clk);
        if (!keep_valid) rv2 = 1'b0;
        lat = 1;
        while (!vld2 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rd = rd2;
        er = err2;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(vld2), 32'd1);
            chk("hold_rdata", rd2, rd);
            chk("hold_err", 32'(err2), 32'(er));
            chk("hold_ready", 32'(rdy2), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        rv2 = 1'b0;
        chk("ready_after_rsp", 32'(rdy2), 32'd1);
        chk("valid_after_rsp", 32'(vld2), 32'd0);
        chk("rdata_after_rsp", rd2, 32'd0);
    endtask

    task automatic go2(input string tag, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        logic [31:0] rd;
        logic er;
        txn2(we, a, wd, be, 1'b0, 0, lat, rd, er);
        chk({tag, "_lat"}, 32'(lat), 32'd3);
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"}, 32'(er), 32'(exp_err));
    endtask

    // Zero-wait transaction: response the cycle after accept, idle the cycle after that.
    task automatic go0(input string tag, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic [31:0] exp_rd, input logic exp_err);
        req_we = we; req_addr = a; req_wdata = wd; req_be = be;
        rv0 = 1'b1;
        chk({tag, "_ready_pre"}, 32'(rdy0), 32'd1);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(vld0), 32'd1);
        chk({tag, "_ready_busy"}, 32'(rdy0), 32'd0);
        chk({tag, "_rdata"}, rd0, exp_rd);
        chk({tag, "_err"}, 32'(err0), 32'(exp_err));
        @(negedge clk);
        chk({tag, "_valid_gone"}, 32'(vld0), 32'd0);
        chk({tag, "_ready_back"}, 32'(rdy0), 32'd1);
    endtask

    initial begin
        int lat;
        logic [31:0] rd;
        logic er;

        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(rdy2), 32'd0);
        chk("rst_valid", 32'(vld2), 32'd0);
        chk("rst_rdata", rd2, 32'd0);
        chk("rst_err", 32'(err2), 32'd0);
        rst = 1'b0;
        #1 chk("post_rst_ready", 32'(rdy2), 32'd1);
        @(negedge clk);

        go2("t1_store", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        go2("t1_load", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        go2("t2_store_b0", 1'b1, 32'h10, 32'h000000AA, 4'b0001, 32'h0, 1'b0);
        go2("t2_load", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEAA, 1'b0);
        go2("t2_store_none", 1'b1, 32'h10, 32'h11223344, 4'b0000, 32'h0, 1'b0);
        go2("t2_load_again", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);

        go2("t3_misaligned", 1'b0, 32'h12, 32'h0, 4'hF, 32'h0, 1'b1);
        go2("t3_range", 1'b0, 32'h400, 32'h0, 4'hF, 32'h0, 1'b1);
        go2("t3_word0", 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 32'h0, 1'b0);
        go2("t3_store_range", 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        go2("t3_word0_kept", 1'b0, 32'h0, 32'h0, 4'h0, 32'h0BADF00D, 1'b0);

        txn2(1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 5, lat, rd, er);
        chk("t4_lat", 32'(lat), 32'd3);
        chk("t4_rdata", rd, 32'hDEADBEAA);
        chk("t4_err", 32'(er), 32'd0);

        go2("t5_clear", 1'b1, 32'h20, 32'h0, 4'hF, 32'h0, 1'b0);
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
        rv2 = 1'b1;
        @(negedge clk);
        rv2 = 1'b0;
        chk("t5_in_wait", 32'(rdy2), 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_ready", 32'(rdy2), 32'd0);
        chk("t5_rst_valid", 32'(vld2), 32'd0);
        chk("t5_rst_rdata", rd2, 32'd0);
        chk("t5_rst_err", 32'(err2), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("t5_ready_after", 32'(rdy2), 32'd1);
        @(negedge clk);
        go2("t5_load", 1'b0, 32'h20, 32'h0, 4'hF, 32'h0, 1'b0);

        rsp_ready = 1'b1;
        go0("t6_store", 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
        go0("t6_load", 1'b0, 32'h10, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
        go0("t6_misaligned", 1'b0, 32'h12, 32'h0, 4'hF, 32'h0, 1'b1);
        rv0 = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
